// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: one ADD and one SHIFT cycle per multiplier bit.
// Define SIGNED_MULT_EN to honour the Signed input (two's-complement operands).
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               St,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   Mcand,
  input  logic [WIDTH-1:0]   Mplier,
  output logic [2*WIDTH-1:0] Product,
  output logic               Idle,
  output logic               Busy,
  output logic               Done
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  logic [2*WIDTH:0] acc;
  logic [WIDTH-1:0] mc;
  logic [CW-1:0]    cnt;
  logic             sgn;
  logic [WIDTH:0]   mc_ext;
  logic [WIDTH:0]   upper_nxt;
  logic             shift_in;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (St) state_nxt = ADD;
      ADD:     state_nxt = SHIFT;
      SHIFT:   state_nxt = (cnt == LAST) ? DONE : ADD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SIGNED_MULT_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                 sgn <= 1'b0;
    else if (state == IDLE && St) sgn <= Signed;
  end
`else
  logic unused_signed;
  assign unused_signed = Signed;
  assign sgn = 1'b0;
`endif

  // The multiplier MSB carries negative weight in signed mode, so the last step subtracts.
  assign mc_ext    = {sgn & mc[WIDTH-1], mc};
  assign upper_nxt = (sgn && cnt == LAST) ? acc[2*WIDTH:WIDTH] - mc_ext
                                          : acc[2*WIDTH:WIDTH] + mc_ext;
  assign shift_in  = sgn & acc[2*WIDTH];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc     <= '0;
      mc      <= '0;
      cnt     <= '0;
      Product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (St) begin
            acc <= {{(WIDTH+1){1'b0}}, Mplier};
            mc  <= Mcand;
            cnt <= '0;
          end
        end
        ADD: begin
          if (acc[0]) acc[2*WIDTH:WIDTH] <= upper_nxt;
        end
        SHIFT: begin
          acc <= {shift_in, acc[2*WIDTH:1]};
          if (cnt != LAST) cnt <= cnt + CW'(1);
        end
        DONE: begin
          Product <= acc[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign Idle = (state == IDLE);
  assign Busy = (state == ADD) || (state == SHIFT);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed, table-driven bench for shift_add_multiplier at WIDTH=8.
// Expected signed results follow SIGNED_MULT_EN the same way the design does.
module tb_shift_add_multiplier;
  localparam int WIDTH = 8;

`ifdef SIGNED_MULT_EN
  localparam logic [15:0] EXP_FD05_S = 16'hFFF1;
  localparam logic [15:0] EXP_FF01_S = 16'hFFFF;
  localparam logic [15:0] EXP_7F81_S = 16'hC0FF;
`else
  localparam logic [15:0] EXP_FD05_S = 16'h04F1;
  localparam logic [15:0] EXP_FF01_S = 16'h00FF;
  localparam logic [15:0] EXP_7F81_S = 16'h3FFF;
`endif

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        St;
  logic        Signed;
  logic [7:0]  Mcand;
  logic [7:0]  Mplier;
  logic [15:0] Product;
  logic        Idle;
  logic        Busy;
  logic        Done;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .St      (St),
    .Signed  (Signed),
    .Mcand   (Mcand),
    .Mplier  (Mplier),
    .Product (Product),
    .Idle    (Idle),
    .Busy    (Busy),
    .Done    (Done)
  );

  typedef struct {
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic        sgn;
    logic [15:0] expected;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // glitchAt >= 0 raises St (with different operands) for one cycle while busy.
  task automatic applyStimulus(input logic [7:0] mc, input logic [7:0] mp, input logic sg,
                               input logic [15:0] expected, input int glitchAt,
                               input string tag);
    int doneEdge;
    int busyCount;
    @(negedge Clk);
    Mcand = mc; Mplier = mp; Signed = sg; St = 1'b1;
    @(posedge Clk); #1;
    St = 1'b0;
    doneEdge  = -1;
    busyCount = 0;
    for (int k = 0; k <= 24; k++) begin
      if (Done) begin
        doneEdge = k;
        break;
      end
      if (Busy) busyCount++;
      if (k == glitchAt) begin
        St = 1'b1; Mcand = ~mc; Mplier = 8'h5A;
      end else begin
        St = 1'b0;
      end
      @(posedge Clk); #1;
    end
    St = 1'b0;
    checkOutput({tag, "_latency"}, doneEdge, 16);
    checkOutput({tag, "_busy_cycles"}, busyCount, 16);
    @(posedge Clk); #1;
    checkOutput({tag, "_done_width"}, {31'b0, Done}, 0);
    checkOutput({tag, "_product"}, {16'b0, Product}, {16'b0, expected});
    checkOutput({tag, "_idle"}, {31'b0, Idle}, 1);
    @(posedge Clk); #1;
    checkOutput({tag, "_idle_hold"}, {31'b0, Idle}, 1);
  endtask

  function automatic logic [7:0] mcOf(input int i);
    mcOf = 8'((17 * i + 3) % 256);
  endfunction

  function automatic logic [7:0] mpOf(input int i);
    mpOf = 8'((29 * i + 7) % 256);
  endfunction

  initial begin
    int doneErr;
    int idleErr;
    logic expDone;
    logic expIdle;

    vecs[0] = '{8'd13,  8'd11,  1'b0, 16'h008F};
    vecs[1] = '{8'd255, 8'd255, 1'b0, 16'hFE01};
    vecs[2] = '{8'd0,   8'd200, 1'b0, 16'h0000};
    vecs[3] = '{8'd200, 8'd0,   1'b0, 16'h0000};
    vecs[4] = '{8'hFD,  8'h05,  1'b1, EXP_FD05_S};
    vecs[5] = '{8'h80,  8'h80,  1'b1, 16'h4000};
    vecs[6] = '{8'hFD,  8'h05,  1'b0, 16'h04F1};
    vecs[7] = '{8'hFF,  8'h01,  1'b1, EXP_FF01_S};
    vecs[8] = '{8'h7F,  8'h81,  1'b1, EXP_7F81_S};
    vecs[9] = '{8'hA5,  8'h3C,  1'b0, 16'h26AC};

    Rst_n = 1'b0; St = 1'b0; Signed = 1'b0; Mcand = '0; Mplier = '0;
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("reset_idle", {31'b0, Idle}, 1);
    checkOutput("reset_busy", {31'b0, Busy}, 0);
    checkOutput("reset_done", {31'b0, Done}, 0);
    checkOutput("reset_product", {16'b0, Product}, 0);
    @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      applyStimulus(vecs[i].mcand, vecs[i].mplier, vecs[i].sgn, vecs[i].expected, -1,
                    $sformatf("vec%0d", i));

    applyStimulus(8'd13, 8'd11, 1'b0, 16'h008F, 3,  "st_while_busy_early");
    applyStimulus(8'd13, 8'd11, 1'b0, 16'h008F, 15, "st_while_busy_late");

    // St held for 40 edges: loads land on edges 0, 18 and 36.
    doneErr = 0;
    idleErr = 0;
    @(negedge Clk);
    St = 1'b1; Signed = 1'b0; Mcand = mcOf(0); Mplier = mpOf(0);
    for (int k = 0; k <= 54; k++) begin
      @(posedge Clk); #1;
      expDone = (k == 16) || (k == 34) || (k == 52);
      expIdle = (k == 17) || (k == 35) || (k >= 53);
      if (Done !== expDone) doneErr++;
      if (Idle !== expIdle) idleErr++;
      if (k == 17 || k == 35 || k == 53)
        checkOutput($sformatf("b2b_product_load%0d", k - 17), {16'b0, Product},
                    {16'b0, ({8'b0, mcOf(k - 17)} * {8'b0, mpOf(k - 17)})});
      @(negedge Clk);
      Mcand = mcOf(k + 1); Mplier = mpOf(k + 1); St = (k + 1 <= 39);
    end
    St = 1'b0;
    checkOutput("b2b_done_pattern_errors", doneErr, 0);
    checkOutput("b2b_idle_pattern_errors", idleErr, 0);

    @(negedge Clk);
    Mcand = 8'd100; Mplier = 8'd100; Signed = 1'b0; St = 1'b1;
    @(posedge Clk); #1;
    St = 1'b0;
    repeat (6) @(posedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    checkOutput("abort_idle", {31'b0, Idle}, 1);
    checkOutput("abort_busy", {31'b0, Busy}, 0);
    checkOutput("abort_done", {31'b0, Done}, 0);
    checkOutput("abort_product", {16'b0, Product}, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    applyStimulus(8'd3, 8'd4, 1'b0, 16'h000C, -1, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
